fu_issue_scheduler: RTL
=======================

Name: fu_issue_scheduler

Overview:
- Selects which issue-queue entries go to the functional units each cycle; one grant per FU per cycle.
- Per-FU round-robin arbitration over the 64 IQ slots; each entry is routed by its 2-bit functional-unit field.
- Sits between the issue queue (use bits, operand-ready bits, FU field) and the 3 functional units (valid/ready handshake).
- Returns a dealloc mask so the issue queue clears use bits of entries handed off.

Parameters:
- NUM_INSTRUCTIONS, 64, IQ entries arbitrated.
- NUM_FUNCTIONAL_UNITS, 3, FU count; one output slot each.
- IQ_INDEX_BITS, $clog2(NUM_INSTRUCTIONS), entry index width.
- FU_SEL_BITS, 2, width of the per-entry FU field.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- entry_valid  in  NUM_INSTRUCTIONS  IQ use bits; 1 = slot occupied.
- entry_ready  in  NUM_INSTRUCTIONS  1 = both source operands ready.
- entry_fu  in  NUM_INSTRUCTIONS*FU_SEL_BITS  FU field; entry i at bits [2i+1:2i].
- fu_ready  in  NUM_FUNCTIONAL_UNITS  FU k accepts an instruction this cycle.
- flush  in  1  synchronous squash of all pending grants.
- issue_valid  out  NUM_FUNCTIONAL_UNITS  registered; slot k holds a grant.
- issue_index  out  NUM_FUNCTIONAL_UNITS*IQ_INDEX_BITS  registered; granted IQ index for FU k at [6k+5:6k].
- dealloc_mask  out  NUM_INSTRUCTIONS  combinational; bit i set when the entry in slot k has issue_valid[k] & fu_ready[k] & !flush.

Behaviour:
- Reset (reset_n=0 at posedge): issue_valid=0, issue_index=0, rr_ptr[k]=0 for all k. dealloc_mask=0 while issue_valid=0.
- held[i]: entry i currently sits in any valid output slot.
- eligible_k[i] = entry_valid[i] & entry_ready[i] & ~held[i] & (entry_fu[i]==k). FU field values >= NUM_FUNCTIONAL_UNITS are never eligible.
- Slot k may load when free: !issue_valid[k], or issue_valid[k] & fu_ready[k] (drain and refill in the same cycle).
- Winner for FU k: first eligible_k index at or after rr_ptr[k], ascending, wrapping 63->0. No eligible entry -> slot empties (issue_valid[k]=0 next cycle if drained).
- On load: issue_valid[k]<=1, issue_index[k]<=winner, rr_ptr[k]<=(winner+1) mod 64.
- Hold: issue_valid[k] & !fu_ready[k] -> issue_index[k] and rr_ptr[k] unchanged. Outputs stay stable until accepted.
- Latency: entry eligible at cycle t -> issue_valid at t+1 at the earliest. Handoff occurs in the cycle where fu_ready is high; dealloc is in the same cycle.
- The draining entry is still in held during its handoff cycle, so it cannot be regranted. The IQ clears its use bit at that edge.
- An entry matches exactly one FU, so no entry is ever granted to two slots.
- flush=1: next cycle issue_valid=0; no loads in the flush cycle; dealloc_mask forced 0; rr_ptr retained.
- Reset mid-handshake dominates flush and all other inputs.
- Held entry whose entry_valid drops without flush is a protocol violation. The slot keeps the entry; the verification bench asserts on it.

Decomposition:
- Shared package: NUM_INSTRUCTIONS, NUM_FUNCTIONAL_UNITS, IQ_INDEX_BITS, FU_SEL_BITS, FU encodings (FU_ALU0=0, FU_ALU1=1, FU_MEM=2). Same package used by the issue queue.
- Sub-module rr_arbiter: 64-bit request vector + 6-bit pointer -> found + 6-bit index. Implement as double-width masked priority search. Instantiated NUM_FUNCTIONAL_UNITS times.
- Slot registers, held mask and dealloc logic stay in the top module.

Test Plan:
- Reset: reset_n=0 for 2 cycles with all entries ready -> issue_valid=000 and dealloc_mask=0 throughout; first grant appears 1 cycle after reset release.
- Round-robin: entries 5,9,60 valid/ready, fu=0, fu_ready[0]=1 -> issue_index[0]=5,9,60,5 on consecutive cycles; dealloc bit for each entry set in its handoff cycle.
- Backpressure: entry 12 granted to FU1 with fu_ready[1]=0 for 4 cycles -> issue_index[1]=12 stable, dealloc_mask=0. fu_ready[1]=1 -> bit 12 set; entry 13 (fu=1) loaded the same edge.
- Wrap: rr_ptr[2]=62, eligible FU2 entries {3,63} -> grants 63 then 3.
- Parallel/invalid: entries 0(fu0), 1(fu1), 2(fu2), 4(fu=3) ready, all fu_ready=1 -> all three slots valid with indices 0,1,2; entry 4 never issued.
- Flush: issue_valid=111 with all fu_ready=1 and flush=1 -> dealloc_mask=0 that cycle; issue_valid=000 next cycle; rr_ptr unchanged (checked by the next grant order).

Source files
------------

// File: rtl/fu_issue_scheduler_pkg.sv
// Shared issue-queue / scheduler sizing and functional-unit encodings.
package fu_issue_scheduler_pkg;
  localparam int NUM_INSTRUCTIONS     = 64;
  localparam int NUM_FUNCTIONAL_UNITS = 3;
  localparam int IQ_INDEX_BITS        = $clog2(NUM_INSTRUCTIONS);
  localparam int FU_SEL_BITS          = 2;

  typedef enum logic [FU_SEL_BITS-1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MEM  = 2'd2
  } fu_sel_e;

  typedef struct packed {
    logic                     vld;
    logic [IQ_INDEX_BITS-1:0] idx;
  } issue_slot_t;
endpackage

// File: rtl/fu_issue_scheduler_rr_arbiter.sv
// Round-robin pick: lowest request at or after ptr_i, wrapping, via a
// double-width search where the lower copy only keeps requests >= ptr_i.
module fu_issue_scheduler_rr_arbiter
  import fu_issue_scheduler_pkg::*;
(
  input  logic [NUM_INSTRUCTIONS-1:0] req_i,
  input  logic [IQ_INDEX_BITS-1:0]    ptr_i,
  output logic                        found_o,
  output logic [IQ_INDEX_BITS-1:0]    idx_o
);
  logic [NUM_INSTRUCTIONS-1:0]   mask;
  logic [2*NUM_INSTRUCTIONS-1:0] dbl;

  always_comb begin
    mask    = {NUM_INSTRUCTIONS{1'b1}} << ptr_i;
    dbl     = {req_i, req_i & mask};
    found_o = |req_i;
    idx_o   = '0;
    // Descending scan so the lowest set bit wins; truncation folds the upper copy back.
    for (int j = 2*NUM_INSTRUCTIONS-1; j >= 0; j--) begin
      if (dbl[j]) idx_o = IQ_INDEX_BITS'(j);
    end
  end
endmodule

// File: rtl/fu_issue_scheduler.sv
// Per-FU round-robin issue selection with registered output slots and
// combinational dealloc mask back to the issue queue.
module fu_issue_scheduler
  import fu_issue_scheduler_pkg::*;
(
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  logic [NUM_INSTRUCTIONS-1:0]                   entry_valid_i,
  input  logic [NUM_INSTRUCTIONS-1:0]                   entry_ready_i,
  input  logic [NUM_INSTRUCTIONS*FU_SEL_BITS-1:0]       entry_fu_i,
  input  logic [NUM_FUNCTIONAL_UNITS-1:0]               fu_ready_i,
  input  logic                                          flush_i,
  output logic [NUM_FUNCTIONAL_UNITS-1:0]               issue_valid_o,
  output logic [NUM_FUNCTIONAL_UNITS*IQ_INDEX_BITS-1:0] issue_index_o,
  output logic [NUM_INSTRUCTIONS-1:0]                   dealloc_mask_o
);
  logic [NUM_FUNCTIONAL_UNITS-1:0]                        vld_q, vld_d;
  logic [NUM_FUNCTIONAL_UNITS-1:0][IQ_INDEX_BITS-1:0]     idx_q, idx_d;
  logic [NUM_FUNCTIONAL_UNITS-1:0][IQ_INDEX_BITS-1:0]     ptr_q, ptr_d;
  logic [NUM_FUNCTIONAL_UNITS-1:0][IQ_INDEX_BITS-1:0]     win;
  logic [NUM_FUNCTIONAL_UNITS-1:0]                        found;
  logic [NUM_FUNCTIONAL_UNITS-1:0]                        load;
  logic [NUM_FUNCTIONAL_UNITS-1:0][NUM_INSTRUCTIONS-1:0]  elig;
  logic [NUM_INSTRUCTIONS-1:0]                            held;
  logic [NUM_INSTRUCTIONS-1:0][FU_SEL_BITS-1:0]           fu_sel;

  assign fu_sel = entry_fu_i;

  // An entry sitting in any valid slot (including one draining this cycle) is not re-grantable.
  always_comb begin
    held = '0;
    for (int k = 0; k < NUM_FUNCTIONAL_UNITS; k++) begin
      if (vld_q[k]) held[idx_q[k]] = 1'b1;
    end
  end

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_FUNCTIONAL_UNITS; k++) begin
      for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
        elig[k][i] = entry_valid_i[i] & entry_ready_i[i] & ~held[i] &
                     (fu_sel[i] == FU_SEL_BITS'(k));
      end
    end
  end

  for (genvar g = 0; g < NUM_FUNCTIONAL_UNITS; g++) begin : g_arb
    fu_issue_scheduler_rr_arbiter u_arb (
      .req_i   (elig[g]),
      .ptr_i   (ptr_q[g]),
      .found_o (found[g]),
      .idx_o   (win[g])
    );
  end

  always_comb begin
    vld_d          = vld_q;
    idx_d          = idx_q;
    ptr_d          = ptr_q;
    load           = '0;
    dealloc_mask_o = '0;
    for (int k = 0; k < NUM_FUNCTIONAL_UNITS; k++) begin
      load[k] = ~flush_i & (~vld_q[k] | fu_ready_i[k]);
      if (vld_q[k] & fu_ready_i[k] & ~flush_i) dealloc_mask_o[idx_q[k]] = 1'b1;
      if (flush_i) begin
        vld_d[k] = 1'b0;
      end else if (load[k]) begin
        vld_d[k] = found[k];
        if (found[k]) begin
          idx_d[k] = win[k];
          ptr_d[k] = win[k] + IQ_INDEX_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vld_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end

  assign issue_valid_o = vld_q;
  assign issue_index_o = idx_q;
endmodule
